mem_data_dump: RTL
==================

# mem_data_dump

Read-side companion to the processor data memory: on a start pulse, walks a contiguous address window through the memory's registered read port and streams each variable as a tagged record over a valid/ready interface toward the debug/trace sink. Real variables occupy one word. Complex variables occupy two consecutive words, packed into one record in the same `{tag, len, hi, lo}` layout the memory's write-side shadow registers use. Sits between `mem_data`'s `addr_r`/`data_out` pins and the trace collector; it never writes memory.

## Interface
- `NADDRE`, 8: memory depth in words; addresses are `$clog2(NADDRE)` bits.
- `NBDATA`, 32: memory word width.
- `clk  in  1`: sole clock, rising edge.
- `rst_n  in  1`: asynchronous, active-low reset.
- `start  in  1`: one-cycle request; sampled only in IDLE.
- `base  in  $clog2(NADDRE)`: first word address, sampled with `start`.
- `count  in  $clog2(NADDRE)+1`: number of records, sampled with `start`.
- `cplx  in  1`: 0 = one word per record, 1 = two words per record; sampled with `start`.
- `tag  in  8`: type code copied into every record; sampled with `start`.
- `busy  out  1`: high from the cycle after an accepted `start` until the cycle after `done`.
- `done  out  1`: one-cycle pulse after the last record handshakes.
- `mem_addr_r  out  $clog2(NADDRE)`: registered read address to memory.
- `mem_data  in  NBDATA`: memory `data_out`, valid one cycle after `mem_addr_r`.
- `rec_valid  out  1`: record available.
- `rec_ready  in  1`: sink accepts a record when both valid and ready are high at a rising edge.
- `rec_data  out  16+2*NBDATA`: `{tag, len[7:0], hi, lo}`.

## Operation
- **FSM states:** IDLE, READ, DRAIN.
  - IDLE → READ on `start` with `count`≠0.
  - IDLE with `start` and `count`=0: `done` pulses the next cycle, no records are emitted, and the FSM stays in IDLE.
  - `start` outside IDLE is ignored.
- **READ:** issues word reads at `base`, `base+1`, …, incrementing modulo `NADDRE` (wrap from `NADDRE-1` to 0).
  - Real record: `len`=1, `hi`=0, `lo`=word.
  - Complex record: `len`=2, `hi`=word at address a, `lo`=word at a+1.
  - Total words read = `count` × (`cplx`?2:1).
  - READ → DRAIN when the last read has been issued.
- **DRAIN:** waits for the in-flight read to land and for the output FIFO to empty. When the final record handshakes, `done` pulses in the next cycle and the FSM returns to IDLE.
- **Buffering and flow control:**
  - Assembled records go into a 2-entry output FIFO.
  - A read is issued in a cycle only if (FIFO occupancy + records in flight or partially assembled) < 2. Backpressure therefore never drops data, and `mem_data` is always consumed in the cycle it is valid.
- **Simultaneous events:** a FIFO push and pop in the same cycle leave occupancy unchanged. With occupancy 2, a pop frees a slot that a read issued in that same cycle may use.
- **Output stability:** `rec_data` holds stable while `rec_valid`=1 and `rec_ready`=0.
- **Reset:** all state clears asynchronously, including mid-operation. Reset values: `busy`=0, `done`=0, `rec_valid`=0, `rec_data`=0, `mem_addr_r`=0, FSM=IDLE, FIFO empty. Partial records are discarded.

## Timing
- Cycle 0: `start` sampled. Cycle 1: `busy`=1 and `mem_addr_r`=`base`. Cycle 2: `mem_data` valid and the record is pushed. Cycle 3: `rec_valid`=1 (real mode).
- Complex mode: first `rec_valid` at cycle 4.
- Sustained throughput with `rec_ready`=1: one record/cycle in real mode, one record per 2 cycles in complex mode.
- Last handshake at cycle N → `done`=1 at cycle N+1 and `busy`=0 from cycle N+2.

## Structure
- **Shared package `mem_dump_pkg`:**
  - `LEN_REAL`=8'd1 and `LEN_CPLX`=8'd2.
  - FSM state enum.
  - Record-width function `16+2*NBDATA`.
- **Sub-module `rec_fifo2`:** parameterised-width 2-entry FIFO exposing push/pop/occupancy. It holds registered outputs and drives `rec_valid` and `rec_data`.

## Test plan
- Real dump, `NADDRE`=8, mem[k]=k+100, `base`=2, `count`=3, `tag`=23, `rec_ready`=1 → records `{23,1,0,102}`, `{23,1,0,103}`, `{23,1,0,104}` on cycles 3, 4, 5; `done` on cycle 6.
- Complex dump, `base`=6, `count`=2, `cplx`=1 → records `{t,2,mem[6],mem[7]}` then `{t,2,mem[0],mem[1]}` (wrap); exactly 4 reads issued.
- Backpressure: real dump of `count`=4 with `rec_ready` low for cycles 3–8 → FIFO fills to 2 and reads stall. After ready rises, all 4 records appear in order with no drop or duplicate, and `rec_data` is stable while stalled.
- `count`=0 → `done` pulses the next cycle, `rec_valid` never asserts, and no address change is required. `start` pulsed while `busy` → no effect on the stream.
- `rst_n` asserted mid-stream, after 2 of 5 records → all outputs go to their reset values immediately. A fresh `start` afterwards produces a clean full dump from the new `base`.

Source files
------------

// File: rtl/mem_dump_pkg.sv
// Shared constants, FSM encoding and record header layout for the data-memory dump path.
// Records are {tag, len, hi, lo}, matching the write-side shadow register layout.
package mem_dump_pkg;

  localparam logic [7:0] LEN_REAL = 8'd1;
  localparam logic [7:0] LEN_CPLX = 8'd2;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_READ,
    ST_DRAIN
  } state_t;

  typedef struct packed {
    logic [7:0] tag;
    logic [7:0] len;
  } hdr_t;

  function automatic int rec_width(input int nbdata);
    return 16 + 2 * nbdata;
  endfunction

endpackage

// File: rtl/rec_fifo2.sv
// Two-entry record FIFO with registered head output; push is visible at the output the next cycle.
// Pop only when the head is valid; push and pop together keep occupancy; the producer must not push when full.
module rec_fifo2 #(
  parameter int W = 80
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push_vld,
  input  logic [W-1:0] push_dat,
  input  logic         pop_rdy,
  output logic [1:0]   occ,
  output logic         out_vld,
  output logic [W-1:0] out_dat
);

  logic [W-1:0] head_q;
  logic [W-1:0] tail_q;
  logic [1:0]   occ_q;
  logic         pop;

  assign pop     = pop_rdy & (occ_q != 2'd0);
  assign occ     = occ_q;
  assign out_vld = (occ_q != 2'd0);
  assign out_dat = head_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q <= '0;
      tail_q <= '0;
      occ_q  <= 2'd0;
    end else begin
      occ_q <= occ_q + {1'b0, push_vld} - {1'b0, pop};
      if (pop) begin
        if (occ_q == 2'd2) begin
          head_q <= tail_q;
          if (push_vld) tail_q <= push_dat;
        end else if (push_vld) begin
          head_q <= push_dat;
        end
      end else if (push_vld) begin
        if (occ_q == 2'd0) head_q <= push_dat;
        else               tail_q <= push_dat;
      end
    end
  end

endmodule

// File: rtl/mem_data_dump.sv
// Walks an address window through the memory's registered read port and streams tagged records.
// First record valid 3 cycles after start (4 in complex mode); reads stall when the 2-entry output FIFO would overflow.
module mem_data_dump
  import mem_dump_pkg::*;
#(
  parameter int NADDRE = 8,
  parameter int NBDATA = 32
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start,
  input  logic [$clog2(NADDRE)-1:0]    base,
  input  logic [$clog2(NADDRE):0]      count,
  input  logic                         cplx,
  input  logic [7:0]                   tag,
  output logic                         busy,
  output logic                         done,
  output logic [$clog2(NADDRE)-1:0]    mem_addr_r,
  input  logic [NBDATA-1:0]            mem_data,
  output logic                         rec_valid,
  input  logic                         rec_ready,
  output logic [rec_width(NBDATA)-1:0] rec_data
);

  localparam int AW = $clog2(NADDRE);
  localparam int RW = rec_width(NBDATA);

  state_t            state_q;
  state_t            state_d;
  logic [AW:0]       recs_left;
  logic              cplx_q;
  logic [7:0]        tag_q;
  logic              wphase;
  logic              rd_vld;
  logic              rd_lo;
  logic [NBDATA-1:0] hi_q;
  logic [1:0]        pend;
  logic [1:0]        occ;
  logic              busy_q;
  logic              done_q;

  logic              start_ok;
  logic              issue;
  logic              issue_first;
  logic              last_issue;
  logic              done_set;
  logic              credit_ok;
  logic              push_vld;
  logic              pop;
  logic [AW-1:0]     addr_nxt;
  hdr_t              hdr;
  logic [NBDATA-1:0] hi_word;
  logic [RW-1:0]     push_dat;

  assign busy = busy_q;
  assign done = done_q;
  assign pop  = rec_valid & rec_ready;

  // pend counts records whose first read is issued but which are not yet in the FIFO;
  // a pop this cycle frees a slot the new record may take.
  assign credit_ok = ({1'b0, occ} + {1'b0, pend}) < (3'd2 + {2'b0, pop});
  assign push_vld  = rd_vld & (~cplx_q | rd_lo);
  assign addr_nxt  = (mem_addr_r == AW'(NADDRE - 1)) ? '0 : mem_addr_r + 1'b1;

  always_comb begin
    hdr.tag  = tag_q;
    hdr.len  = cplx_q ? LEN_CPLX : LEN_REAL;
    hi_word  = cplx_q ? hi_q : {NBDATA{1'b0}};
    push_dat = {hdr, hi_word, mem_data};
  end

  always_comb begin
    state_d     = state_q;
    start_ok    = 1'b0;
    issue       = 1'b0;
    issue_first = 1'b0;
    last_issue  = 1'b0;
    done_set    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (count != '0) begin
            start_ok = 1'b1;
            state_d  = ST_READ;
          end else begin
            done_set = 1'b1;
          end
        end
      end
      ST_READ: begin
        // The second word of a complex record was already credited with its first word.
        issue       = wphase | credit_ok;
        issue_first = issue & ~wphase;
        last_issue  = issue & (cplx_q ? (wphase & (recs_left == '0))
                                      : (recs_left == {{AW{1'b0}}, 1'b1}));
        if (last_issue) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (pop && occ == 2'd1 && pend == 2'd0) begin
          done_set = 1'b1;
          state_d  = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      recs_left  <= '0;
      cplx_q     <= 1'b0;
      tag_q      <= '0;
      wphase     <= 1'b0;
      rd_vld     <= 1'b0;
      rd_lo      <= 1'b0;
      hi_q       <= '0;
      pend       <= 2'd0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      mem_addr_r <= '0;
    end else begin
      state_q <= state_d;
      done_q  <= done_set;
      rd_vld  <= issue;
      rd_lo   <= issue & wphase;
      pend    <= pend + {1'b0, issue_first} - {1'b0, push_vld};

      if (start_ok)    busy_q <= 1'b1;
      else if (done_q) busy_q <= 1'b0;

      if (start_ok) begin
        recs_left  <= count;
        cplx_q     <= cplx;
        tag_q      <= tag;
        mem_addr_r <= base;
        wphase     <= 1'b0;
      end else if (issue) begin
        mem_addr_r <= addr_nxt;
        wphase     <= cplx_q & ~wphase;
        if (issue_first) recs_left <= recs_left - 1'b1;
      end

      if (rd_vld && cplx_q && !rd_lo) hi_q <= mem_data;
    end
  end

  rec_fifo2 #(
    .W (RW)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push_vld (push_vld),
    .push_dat (push_dat),
    .pop_rdy  (rec_ready),
    .occ      (occ),
    .out_vld  (rec_valid),
    .out_dat  (rec_data)
  );

endmodule
